// File: rtl/dispatch_pkg.sv
// Shared dispatch types: tag/register widths, holder states, RST entry.
// Used by the rename stage and its tag prefetch buffer.
package dispatch_pkg;

  localparam int TAG_WIDTH     = 6;
  localparam int NUM_ARCH_REGS = 32;
  localparam int AREG_WIDTH    = 5;

  typedef logic [TAG_WIDTH-1:0]  tag_t;
  typedef logic [AREG_WIDTH-1:0] areg_t;

  typedef enum logic [1:0] {
    HOLD_EMPTY = 2'd0,
    HOLD_WAIT  = 2'd1,
    HOLD_FULL  = 2'd2
  } hold_state_e;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } rst_entry_t;

endpackage

// File: rtl/rename_stage_if.sv
// Dispatch bundle between the decoder and the rename stage.
// master = decoder side, slave = rename stage.
interface rename_stage_if
  import dispatch_pkg::*;
();

  logic  disp_valid;
  logic  disp_ready;
  areg_t rs_addr;
  areg_t rt_addr;
  areg_t rd_addr;
  logic  rd_write;
  tag_t  rs_tag;
  tag_t  rt_tag;
  logic  rs_pend;
  logic  rt_pend;
  tag_t  rd_tag;
  logic  disp_fire;

  modport master (
    output disp_valid, rs_addr, rt_addr,
    output rd_addr, rd_write,
    input  disp_ready, rs_tag, rt_tag,
    input  rs_pend, rt_pend, rd_tag,
    input  disp_fire
  );

  modport slave (
    input  disp_valid, rs_addr, rt_addr,
    input  rd_addr, rd_write,
    output disp_ready, rs_tag, rt_tag,
    output rs_pend, rt_pend, rd_tag,
    output disp_fire
  );

endinterface

// File: rtl/rename_stage_tag_prefetch_buffer.sv
// Holds one prefetched free tag popped from the free-tag FIFO.
// FIFO data arrives one cycle after the pop request.
module tag_prefetch_buffer
  import dispatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic consume,
  input  logic ef_tf,
  input  tag_t tagout_tf,
  output logic ren_tf,
  output tag_t hold_tag,
  output logic full
);

  hold_state_e state, state_nx;

  // State register and tag capture; flush drops any in-flight tag
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HOLD_EMPTY;
      hold_tag <= '0;
    end else begin
      state <= state_nx;
      if (flush)
        hold_tag <= '0;
      else if (state == HOLD_WAIT)
        hold_tag <= tagout_tf;
    end
  end

  // Next state and pop request
  always_comb begin
    state_nx = state;
    ren_tf   = 1'b0;
    if (reset || flush) begin
      state_nx = HOLD_EMPTY;
    end else begin
      unique case (state)
        HOLD_EMPTY: begin
          ren_tf = ~ef_tf;
          if (ren_tf)
            state_nx = HOLD_WAIT;
        end
        HOLD_WAIT: state_nx = HOLD_FULL;
        HOLD_FULL: begin
          if (consume) begin
            ren_tf   = ~ef_tf;
            state_nx = ren_tf ? HOLD_WAIT
                              : HOLD_EMPTY;
          end
        end
        default: state_nx = HOLD_EMPTY;
      endcase
    end
  end

  assign full = (state == HOLD_FULL);

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: RST lookup, rd tag allocation, CDB clear.
// Optional macro CDB_BYPASS_EN forwards same-cycle CDB clears to lookups.
module rename_stage
  import dispatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  rename_stage_if.slave disp,
  input  tag_t cdb_tag,
  input  logic cdb_tag_valid,
  input  tag_t tagout_tf,
  input  logic ef_tf,
  output logic ren_tf
);

  rst_entry_t rst_q [NUM_ARCH_REGS];
  rst_entry_t rs_e, rt_e;
  tag_t hold_tag;
  logic full, alloc, fire, consume;
  logic rs_byp, rt_byp;

  assign alloc = disp.rd_write & (disp.rd_addr != '0);
  assign disp.disp_ready = ~flush & ~reset
                         & (~alloc | full);
  assign fire = disp.disp_valid & disp.disp_ready;
  assign consume = fire & alloc;
  assign disp.disp_fire = fire;
  assign disp.rd_tag = consume ? hold_tag : '0;

  tag_prefetch_buffer u_pf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .consume   (consume),
    .ef_tf     (ef_tf),
    .tagout_tf (tagout_tf),
    .ren_tf    (ren_tf),
    .hold_tag  (hold_tag),
    .full      (full)
  );

  assign rs_e = rst_q[disp.rs_addr];
  assign rt_e = rst_q[disp.rt_addr];

`ifdef CDB_BYPASS_EN
  assign rs_byp = cdb_tag_valid & (rs_e.tag == cdb_tag);
  assign rt_byp = cdb_tag_valid & (rt_e.tag == cdb_tag);
`else
  assign rs_byp = 1'b0;
  assign rt_byp = 1'b0;
`endif

  assign disp.rs_pend = rs_e.valid & ~rs_byp
                      & (disp.rs_addr != '0);
  assign disp.rt_pend = rt_e.valid & ~rt_byp
                      & (disp.rt_addr != '0);
  assign disp.rs_tag = disp.rs_pend ? rs_e.tag : '0;
  assign disp.rt_tag = disp.rt_pend ? rt_e.tag : '0;

  // RST update: CDB clears first, rename write overrides
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++)
        rst_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++)
        rst_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ARCH_REGS; i++)
        if (cdb_tag_valid && rst_q[i].valid
            && rst_q[i].tag == cdb_tag)
          rst_q[i].valid <= 1'b0;
      if (consume)
        rst_q[disp.rd_addr] <= '{valid: 1'b1,
                                 tag: hold_tag};
    end
  end

endmodule
